// File: rtl/fifo_id_buf_pkg.sv
// ============================================================================
// fifo_id_buf_pkg
// Shared constants for the fetch-to-decode instruction bundle buffer:
// NOP encoding, reset PC, default sideband field widths and a saturating
// counter helper.
// Revision: 1.0
// ============================================================================
`default_nettype none

package fifo_id_buf_pkg;

    // Encoding presented in every slot while no bundle is available.
    localparam logic [31:0] INST_NOP = 32'h0340_0000;

    // PC shown on the outputs while no bundle is available.
    localparam logic [31:0] PC_RESET = 32'h1c00_0000;

    // Default sideband layout: badv, cookie, exception code, exception flag,
    // ibar flag and cacop bits.
    localparam int SIDE_BADV_W      = 32;
    localparam int SIDE_COOKIE_W    = 32;
    localparam int SIDE_EXCP_W      = 6;
    localparam int SIDE_EXCP_FLAG_W = 1;
    localparam int SIDE_IBAR_W      = 1;
    localparam int SIDE_CACOP_W     = 3;
    localparam int SIDE_W_DEF       = SIDE_BADV_W + SIDE_COOKIE_W + SIDE_EXCP_W
                                    + SIDE_EXCP_FLAG_W + SIDE_IBAR_W + SIDE_CACOP_W;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_id_buf.sv
// ============================================================================
// fifo_id_buf
// Circular buffer of instruction bundles between the fetch buffer and decode.
// Head entry drives the outputs straight from storage; an empty buffer shows
// a NOP bundle. Also tracks the last flush cause and decode-starved cycles.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fifo_id_buf
    import fifo_id_buf_pkg::*;
#(
    parameter int ISSUE_W = 2,
    parameter int DEPTH   = 2,
    parameter int SIDE_W  = SIDE_W_DEF
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          flush,
    input  logic [1:0]                    flush_cause,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [ISSUE_W-1:0]            in_slot_vld,
    input  logic [32*ISSUE_W-1:0]         in_inst,
    input  logic [31:0]                   in_pc,
    input  logic [SIDE_W-1:0]             in_side,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ISSUE_W-1:0]            out_slot_vld,
    output logic [32*ISSUE_W-1:0]         out_inst,
    output logic [31:0]                   out_pc,
    output logic [SIDE_W-1:0]             out_side,
    output logic [$clog2(DEPTH+1)-1:0]    count,
    output logic [1:0]                    last_flush_cause,
    output logic [31:0]                   bubble_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    // Bundle storage; contents are only meaningful between head and tail.
    logic [ISSUE_W-1:0]    slot_vld_mem [DEPTH];
    logic [32*ISSUE_W-1:0] inst_mem     [DEPTH];
    logic [31:0]           pc_mem       [DEPTH];
    logic [SIDE_W-1:0]     side_mem     [DEPTH];

    logic [PTR_W-1:0] head_q,   head_d;
    logic [PTR_W-1:0] tail_q,   tail_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic [1:0]       cause_q,  cause_d;
    logic [31:0]      bubble_q, bubble_d;

    logic full;
    logic empty;
    logic push;
    logic pop;

    // Handshakes; in_ready depends only on occupancy, so a pop never frees
    // room for a push in the same cycle. Flush suppresses both.
    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);
    assign push  = in_valid && !full && !flush;
    assign pop   = out_ready && !empty && !flush;

    // Next-state for pointers, occupancy, flush cause and bubble counter.
    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        cause_d  = cause_q;
        bubble_d = bubble_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            cause_d = flush_cause;
        end else begin
            if (push) begin
                tail_d = tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
        if (out_ready && empty && !flush) begin
            bubble_d = sat_inc32(bubble_q);
        end
    end

    // Control state with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            cause_q  <= '0;
            bubble_q <= '0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            cause_q  <= cause_d;
            bubble_q <= bubble_d;
        end
    end

    // Storage write at the tail; no reset since occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            slot_vld_mem[tail_q] <= in_slot_vld;
            inst_mem[tail_q]     <= in_inst;
            pc_mem[tail_q]       <= in_pc;
            side_mem[tail_q]     <= in_side;
        end
    end

    // Head entry straight from storage, or the NOP bundle when empty.
    always_comb begin
        out_valid    = !empty;
        in_ready     = !full;
        out_slot_vld = '0;
        out_inst     = {ISSUE_W{INST_NOP}};
        out_pc       = PC_RESET;
        out_side     = '0;
        if (!empty) begin
            out_slot_vld = slot_vld_mem[head_q];
            out_inst     = inst_mem[head_q];
            out_pc       = pc_mem[head_q];
            out_side     = side_mem[head_q];
        end
    end

    assign count            = count_q;
    assign last_flush_cause = cause_q;
    assign bubble_cnt       = bubble_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_id_buf.sv
// ============================================================================
// tb_fifo_id_buf
// Self-checking bench for fifo_id_buf: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fifo_id_buf;

    localparam int ISSUE_W = 2;
    localparam int DEPTH   = 2;
    localparam int SIDE_W  = 75;
    localparam logic [31:0] NOP  = 32'h0340_0000;
    localparam logic [31:0] PC_R = 32'h1c00_0000;

    typedef struct {
        logic [ISSUE_W-1:0]    sv;
        logic [32*ISSUE_W-1:0] inst;
        logic [31:0]           pc;
        logic [SIDE_W-1:0]     side;
    } bundle_t;

    logic                   clk = 1'b0;
    logic                   rstn;
    logic                   flush;
    logic [1:0]             flush_cause;
    logic                   in_valid;
    logic                   in_ready;
    logic [ISSUE_W-1:0]     in_slot_vld;
    logic [32*ISSUE_W-1:0]  in_inst;
    logic [31:0]            in_pc;
    logic [SIDE_W-1:0]      in_side;
    logic                   out_valid;
    logic                   out_ready;
    logic [ISSUE_W-1:0]     out_slot_vld;
    logic [32*ISSUE_W-1:0]  out_inst;
    logic [31:0]            out_pc;
    logic [SIDE_W-1:0]      out_side;
    logic [1:0]             count;
    logic [1:0]             last_flush_cause;
    logic [31:0]            bubble_cnt;

    bundle_t cur;
    assign in_slot_vld = cur.sv;
    assign in_inst     = cur.inst;
    assign in_pc       = cur.pc;
    assign in_side     = cur.side;

    always #5 clk = ~clk;

    fifo_id_buf #(.ISSUE_W(ISSUE_W), .DEPTH(DEPTH), .SIDE_W(SIDE_W)) dut (
        .clk              (clk),
        .rstn             (rstn),
        .flush            (flush),
        .flush_cause      (flush_cause),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_slot_vld      (in_slot_vld),
        .in_inst          (in_inst),
        .in_pc            (in_pc),
        .in_side          (in_side),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_slot_vld     (out_slot_vld),
        .out_inst         (out_inst),
        .out_pc           (out_pc),
        .out_side         (out_side),
        .count            (count),
        .last_flush_cause (last_flush_cause),
        .bubble_cnt       (bubble_cnt)
    );

    // Reference model state.
    bundle_t     mq[$];
    logic [1:0]  m_cause;
    logic [31:0] m_bubble;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bundle_t rand_bundle();
        bundle_t b;
        b.sv = ISSUE_W'($urandom);
        for (int s = 0; s < ISSUE_W; s++) b.inst[32*s +: 32] = $urandom;
        b.pc   = $urandom & 32'hFFFF_FFFC;
        b.side = SIDE_W'({$urandom, $urandom, $urandom});
        return b;
    endfunction

    // Compare every observable output with the model.
    task automatic check_outs(input string tag);
        bundle_t h;
        if (mq.size() != 0) begin
            h = mq[0];
        end else begin
            h.sv = '0; h.inst = {ISSUE_W{NOP}}; h.pc = PC_R; h.side = '0;
        end
        check({tag, ".out_valid"}, out_valid, mq.size() != 0);
        check({tag, ".in_ready"},  in_ready,  mq.size() != DEPTH);
        check({tag, ".count"},     count,     mq.size());
        check({tag, ".slot_vld"},  out_slot_vld, h.sv);
        check({tag, ".inst"},      out_inst,  h.inst);
        check({tag, ".pc"},        out_pc,    h.pc);
        check({tag, ".side"},      out_side,  h.side);
        check({tag, ".cause"},     last_flush_cause, m_cause);
        check({tag, ".bubble"},    bubble_cnt, m_bubble);
    endtask

    // One clock with the currently driven inputs; model advances in step.
    task automatic cycle();
        bit push, pop, bub;
        bundle_t b;
        b    = cur;
        push = in_valid && (mq.size() != DEPTH) && !flush;
        pop  = out_ready && (mq.size() != 0) && !flush;
        bub  = out_ready && (mq.size() == 0) && !flush;
        #3;
        check("in_ready_pre_edge", in_ready, mq.size() != DEPTH);
        @(posedge clk);
        #1;
        if (flush) begin
            mq.delete();
            m_cause = flush_cause;
        end else begin
            if (pop)  void'(mq.pop_front());
            if (push) mq.push_back(b);
        end
        if (bub && m_bubble != 32'hFFFF_FFFF) m_bubble++;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; flush_cause = 2'b00;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        #1;
        mq.delete(); m_cause = 2'b00; m_bubble = '0;
        check_outs("reset_async");
        @(posedge clk); #1;
        rstn = 1'b1;
        check_outs("reset_release");
    endtask

    initial begin
        bundle_t a, b, c, d;
        idle_inputs();
        cur  = rand_bundle();
        rstn = 1'b1;
        m_cause = 2'b00; m_bubble = '0;
        #2;
        do_reset();

        // Push A into empty buffer: visible next cycle.
        a = rand_bundle(); a.pc = 32'h1c00_0000;
        cur = a; in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        check("push_a.valid", out_valid, 1'b1);
        check("push_a.pc",    out_pc,    32'h1c00_0000);
        check("push_a.count", count,     2'd1);
        check_outs("push_a");
        out_ready = 1'b1; cycle(); out_ready = 1'b0;
        check_outs("pop_a");

        // Fill to full, then pop while offering C: C must be refused.
        a = rand_bundle(); b = rand_bundle(); c = rand_bundle();
        cur = a; in_valid = 1'b1; cycle();
        cur = b; cycle();
        check("full.in_ready", in_ready, 1'b0);
        check("full.count",    count,    2'd2);
        cur = c; out_ready = 1'b1; cycle();
        in_valid = 1'b0;
        check("full_pop.count", count,  2'd1);
        check("full_pop.pc",    out_pc, b.pc);
        check_outs("full_pop");

        // Simultaneous push and pop at count 1.
        d = rand_bundle(); cur = d; in_valid = 1'b1; out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        check("pushpop.count", count,  2'd1);
        check("pushpop.pc",    out_pc, d.pc);
        check_outs("pushpop");
        cycle();
        out_ready = 1'b0;
        check_outs("drain_d");

        // Flush while full with a push offered.
        in_valid = 1'b1; cur = rand_bundle(); cycle(); cur = rand_bundle(); cycle();
        flush = 1'b1; flush_cause = 2'b10; cur = rand_bundle(); out_ready = 1'b1;
        cycle();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        check("flush.count", count,    2'd0);
        check("flush.inst",  out_inst, {NOP, NOP});
        check("flush.cause", last_flush_cause, 2'b10);
        check_outs("flush");

        // Bubble counting and saturation.
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) cycle();
        check("bubble5", bubble_cnt, 32'd5);
        force dut.bubble_q = 32'hFFFF_FFFE;
        #1;
        release dut.bubble_q;
        m_bubble = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) cycle();
        check("bubble_sat", bubble_cnt, 32'hFFFF_FFFF);
        out_ready = 1'b0;

        // Asynchronous reset in the middle of traffic.
        in_valid = 1'b1; cur = rand_bundle(); cycle(); cur = rand_bundle(); cycle();
        in_valid = 1'b0;
        #2;
        do_reset();
        check("rst_mid.count", count, 2'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            in_valid    = 1'($urandom_range(0, 1));
            out_ready   = 1'($urandom_range(0, 1));
            flush       = ($urandom_range(0, 19) == 0);
            flush_cause = 2'($urandom);
            cur         = rand_bundle();
            cycle();
            check_outs("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/fifo_id_buf.md
FIFO_ID_BUF -- requirements
Module: fifo_id_buf

Interface
REQ-001 SHALL have parameter ISSUE_W, default 2, instruction slots per bundle (1..4).
REQ-002 SHALL have parameter DEPTH, default 2, bundle entries, a power of two of at least 2.
REQ-003 SHALL have parameter SIDE_W, default 75, per-bundle sideband (badv, cookie, exception, excp_flag, ibar_flag, cacop bits).
REQ-004 SHALL have port clk  in  1  the single clock, rising edge.
REQ-005 SHALL have port rstn  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port flush  in  1  discards all held and incoming bundles.
REQ-007 SHALL have port flush_cause  in  2  cause code, sampled with flush.
REQ-008 SHALL have port in_valid  in  1  fetch-buffer bundle valid.
REQ-009 SHALL have port in_ready  out  1  buffer accepts a bundle.
REQ-010 SHALL have port in_slot_vld  in  ISSUE_W  per-slot valid.
REQ-011 SHALL have port in_inst  in  32*ISSUE_W  instructions, slot 0 in the LSBs.
REQ-012 SHALL have port in_pc  in  32  PC of slot 0.
REQ-013 SHALL have port in_side  in  SIDE_W  sideband.
REQ-014 SHALL have port out_valid  out  1  bundle presented to decode.
REQ-015 SHALL have port out_ready  in  1  decode consumes the bundle.
REQ-016 SHALL have ports out_slot_vld, out_inst, out_pc and out_side, all outputs of the same widths as their in_ counterparts.
REQ-017 SHALL have port count  out  $clog2(DEPTH+1)  occupancy.
REQ-018 SHALL have port last_flush_cause  out  2  cause of the most recent flush.
REQ-019 SHALL have port bubble_cnt  out  32  decode-starved cycle counter.

Function
REQ-020 SHALL implement a circular FIFO of DEPTH entries with wrapping head/tail pointers; push when in_valid&&in_ready, pop when out_valid&&out_ready.
REQ-021 SHALL drive in_ready = (count!=DEPTH), with no combinational path from out_ready.
REQ-022 SHALL drive out_valid = (count!=0); head-entry fields drive the outputs directly from storage.
REQ-023 SHALL give a latency of 1 cycle: a bundle pushed into an empty buffer appears at the outputs on the next cycle.
REQ-024 SHALL, when out_valid=0, force out_inst to INST_NOP in every slot, out_slot_vld=0, out_pc=PC_RESET and out_side=0.
REQ-025 SHALL, on a simultaneous push and pop, leave count unchanged and advance both pointers.
REQ-026 SHALL, when full, not accept a push (in_ready=0) even if a pop occurs in the same cycle.
REQ-027 SHALL treat a pop attempt when empty as a no-op.
REQ-028 SHALL, on flush, zero count, head and tail on the next edge, drop any same-cycle push, and not count a same-cycle pop; flush has priority over all other actions.
REQ-029 SHALL load last_flush_cause from flush_cause on each flush; otherwise it holds its value.
REQ-030 SHALL increment bubble_cnt when out_ready&&!out_valid&&!flush, saturating at 32'hFFFFFFFF.
REQ-031 SHALL forward slots with in_slot_vld clear unchanged; the slot-valid bits travel with the bundle.

Reset
REQ-032 SHALL, on rstn low, asynchronously clear count, pointers, last_flush_cause and bubble_cnt, and show the NOP-bundle outputs defined in REQ-024.
REQ-033 SHALL, on reset asserted mid-operation, discard all stored bundles; storage contents need no reset.

Structure
REQ-034 SHALL take INST_NOP and PC_RESET from the shared define header, and SHALL define the default sideband field widths as constants there.
REQ-035 SHALL be a single module; the storage array and pointer logic are not split into a sub-module.

Verification
REQ-036 SHALL verify with ISSUE_W=2, DEPTH=2: push A (pc 0x1c000000) into an empty buffer -> out_valid=1 and out_pc=0x1c000000 next cycle, count=1.
REQ-037 SHALL verify: push A,B with out_ready=0 -> in_ready=0 and count=2; then out_ready=1 with in_valid=1 -> A popped and C not accepted that cycle.
REQ-038 SHALL verify: count=1 with push and pop in the same cycle -> count stays 1 and the next bundle appears in order.
REQ-039 SHALL verify: flush=1 with cause 2'b10 while count=2 and in_valid=1 -> count=0, out_inst=INST_NOP in both slots, last_flush_cause=2'b10.
REQ-040 SHALL verify: 5 cycles of out_ready=1 on an empty buffer -> bubble_cnt=5; preloaded with 32'hFFFFFFFE -> bubble_cnt saturates at 32'hFFFFFFFF.
REQ-041 SHALL verify: rstn pulsed low mid-stream -> outputs revert to the NOP bundle asynchronously, and count=0 after release.
